// File: rtl/mcm6264c_ctrl.sv
// Clocked request/response controller for an 8k x 8 MCM6264C-style asynchronous SRAM.
// Define MCM6264C_CTRL_RSPBUF_EN to add rsp_ready backpressure on the read response.
module mcm6264c_ctrl #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter int unsigned RD_WAIT_CYC  = 2,
  parameter int unsigned HOLD_CYC     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef MCM6264C_CTRL_RSPBUF_EN
  input  logic              rsp_ready,
`endif
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              sram_e1_n,
  output logic              sram_e2,
  output logic              sram_w_n,
  output logic              sram_g_n
);

  typedef enum logic [2:0] {IDLE, SETUP, WPULSE, RPULSE, HOLD} state_t;

  localparam logic [3:0] CNT_SETUP = 4'(SETUP_CYC - 1);
  localparam logic [3:0] CNT_WR    = 4'(WR_PULSE_CYC - 1);
  localparam logic [3:0] CNT_RD    = 4'(RD_WAIT_CYC - 1);
  localparam logic [3:0] CNT_HOLD  = 4'(HOLD_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;
  logic       rsp_done;
  logic       rsp_stall;

  // rsp_done clears rsp_valid; rsp_stall keeps the FSM parked in the last HOLD cycle.
  always_comb begin
    rsp_done  = 1'b1;
    rsp_stall = 1'b0;
`ifdef MCM6264C_CTRL_RSPBUF_EN
    rsp_done  = rsp_valid && rsp_ready;
    rsp_stall = rsp_valid && !rsp_ready;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_e1_n <= 1'b1;
      sram_e2   <= 1'b0;
      sram_w_n  <= 1'b1;
      sram_g_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            sram_addr <= req_addr;
            sram_din  <= req_wdata;
            we_q      <= req_we;
            sram_e1_n <= 1'b0;
            sram_e2   <= 1'b1;
            cnt       <= CNT_SETUP;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            if (we_q) begin
              sram_w_n <= 1'b0;
              cnt      <= CNT_WR;
              state    <= WPULSE;
            end else begin
              sram_g_n <= 1'b0;
              cnt      <= CNT_RD;
              state    <= RPULSE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WPULSE: begin
          if (cnt == '0) begin
            sram_w_n <= 1'b1;
            cnt      <= CNT_HOLD;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RPULSE: begin
          if (cnt == '0) begin
            sram_g_n  <= 1'b1;
            rsp_rdata <= sram_dout;
            rsp_valid <= 1'b1;
            cnt       <= CNT_HOLD;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (rsp_done) rsp_valid <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (!rsp_stall) begin
            sram_e1_n <= 1'b1;
            sram_e2   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcm6264c_ctrl.sv
// Randomized self-checking bench for mcm6264c_ctrl against a transaction-level timing and memory model.
module tb_mcm6264c_ctrl;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;
  localparam int unsigned S  = 1;
  localparam int unsigned P  = 2;
  localparam int unsigned R  = 2;
  localparam int unsigned H  = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
`ifdef MCM6264C_CTRL_RSPBUF_EN
  logic          rsp_ready;
`endif
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          sram_e1_n;
  logic          sram_e2;
  logic          sram_w_n;
  logic          sram_g_n;

  always #5 clk = ~clk;

  mcm6264c_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S), .WR_PULSE_CYC(P), .RD_WAIT_CYC(R), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef MCM6264C_CTRL_RSPBUF_EN
    .rsp_ready(rsp_ready),
`endif
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_e1_n(sram_e1_n), .sram_e2(sram_e2), .sram_w_n(sram_w_n), .sram_g_n(sram_g_n)
  );

  // Behavioural SRAM; undriven reads return a marker so mistimed captures show up.
  logic [DW-1:0] mem     [0:8191];
  logic [DW-1:0] ref_mem [0:8191];
  bit            known   [0:8191];

  always @(posedge clk)
    if (!sram_e1_n && sram_e2 && !sram_w_n) mem[sram_addr] = sram_din;

  assign sram_dout = (!sram_e1_n && sram_e2 && !sram_g_n) ? mem[sram_addr] : 8'hEE;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // One transaction; every cycle is checked against the expected strobe schedule.
  task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit          ok;
    int unsigned last;
    bit          en;
    bit          strobe;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    last = S + (we ? P : R) + H + 1;
    for (int unsigned c = 1; c <= last; c++) begin
      @(negedge clk);
      req_valid = (c < last) ? 1'($urandom) : 1'b0;
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      en     = (c < last);
      strobe = (c > S) && (c <= S + (we ? P : R));
      check("e1_n", 32'(sram_e1_n), 32'(!en));
      check("e2", 32'(sram_e2), 32'(en));
      check("w_n", 32'(sram_w_n), 32'(!(we && strobe)));
      check("g_n", 32'(sram_g_n), 32'(!(!we && strobe)));
      check("req_ready", 32'(req_ready), 32'(c == last));
      check("rsp_valid", 32'(rsp_valid), 32'(!we && (c == S + R + 1)));
      if (en) check("addr", 32'(sram_addr), 32'(addr));
      if (en && we) check("din", 32'(sram_din), 32'(data));
      if (!we && (c == S + R + 1) && known[addr]) check("rdata", 32'(rsp_rdata), 32'(ref_mem[addr]));
    end
    if (we) begin
      ref_mem[addr] = data;
      known[addr]   = 1'b1;
      check("mem", 32'(mem[addr]), 32'(data));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [DW-1:0] v;
    for (int i = 0; i < 8192; i++) begin
      v          = DW'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
      known[i]   = 1'b1;
    end
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef MCM6264C_CTRL_RSPBUF_EN
    rsp_ready = 1'b1;
`endif

    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
    end
    check("rst_e1_n", 32'(sram_e1_n), 32'd1);
    check("rst_e2", 32'(sram_e2), 32'd0);
    check("rst_w_n", 32'(sram_w_n), 32'd1);
    check("rst_g_n", 32'(sram_g_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_din", 32'(sram_din), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    txn(1'b1, 13'h0064, 8'hA5);
    txn(1'b0, 13'h0064, 8'h00);
    txn(1'b1, 13'h1FFE, 8'h01);
    txn(1'b1, 13'h1FFF, 8'h02);
    txn(1'b0, 13'h1FFE, 8'h00);
    txn(1'b0, 13'h1FFF, 8'h00);

    // Reset during the write pulse.
    wait_ready(ok);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 13'h0010;
    req_wdata = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (S) @(negedge clk);
    check("abort_w_low", 32'(sram_w_n), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_w_n", 32'(sram_w_n), 32'd1);
    check("abort_e1_n", 32'(sram_e1_n), 32'd1);
    check("abort_e2", 32'(sram_e2), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    known[13'h0010] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 13'h0020, 8'h00);

`ifdef MCM6264C_CTRL_RSPBUF_EN
    wait_ready(ok);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 13'h0064;
    repeat (S + R) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", 32'(rsp_rdata), 32'(ref_mem[13'h0064]));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_e1_n", 32'(sram_e1_n), 32'd0);
      check("bp_g_n", 32'(sram_g_n), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp_clear", 32'(rsp_valid), 32'd0);
    check("bp_ready_back", 32'(req_ready), 32'd1);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      txn(1'($urandom), a, DW'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("idle_e1_n", 32'(sram_e1_n), 32'd1);
        check("idle_ready", 32'(req_ready), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
